rrp_otf_conv: RTL

RRP_OTF_CONV -- requirements
Module: rRp_otf_conv

---
 rtl/rrp_otf_conv_pkg.sv | 23 ++
 rtl/rrp_otf_conv_if.sv | 31 +++
 rtl/rrp_otf_conv_step.sv | 38 +++
 rtl/rrp_otf_conv.sv | 89 ++++++++
 4 files changed

// File: rtl/rrp_otf_conv_pkg.sv
// Shared sizing helpers and FSM state type for the redundant-to-binary
// on-the-fly converter and its companion multiplier benches.
package rrp_otf_conv_pkg;

    function automatic int digit_bits(input int radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int num_digits(input int width);
        return 2 * width + 1;
    endfunction

    function automatic int out_bits(input int radix, input int width);
        return num_digits(width) * $clog2(radix) + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rrp_otf_conv_if.sv
// Valid/ready handshake bundle carrying the signed-digit word in and the
// two's-complement result out.
interface rrp_otf_conv_if #(
    parameter int RADIX = 4,
    parameter int WIDTH = 4
);
    import rrp_otf_conv_pkg::*;

    localparam int D     = digit_bits(RADIX);
    localparam int NDIG  = num_digits(WIDTH);
    localparam int OUT_W = out_bits(RADIX, WIDTH);

    logic                in_valid;
    logic [D*NDIG-1:0]   in_data;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic                out_err;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_err
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_err
    );

endinterface

// File: rtl/rrp_otf_conv_step.sv
// One on-the-fly conversion step: shifts Q/QM by one digit and appends the
// new digit field, so no carry chain spans the result width.
module rrp_otf_conv_step
    import rrp_otf_conv_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int WIDTH = 4
) (
    input  logic [out_bits(RADIX, WIDTH)-1:0] q_i,
    input  logic [out_bits(RADIX, WIDTH)-1:0] qm_i,
    input  logic [digit_bits(RADIX)-1:0]      dig_i,
    output logic [out_bits(RADIX, WIDTH)-1:0] q_o,
    output logic [out_bits(RADIX, WIDTH)-1:0] qm_o,
    output logic                              bad_o
);
    localparam int D     = digit_bits(RADIX);
    localparam int OUT_W = out_bits(RADIX, WIDTH);
    localparam int LB    = $clog2(RADIX);

    logic             dig_neg;
    logic             dig_pos;
    logic [OUT_W-1:0] q_src;
    logic [OUT_W-1:0] qm_src;
    logic [LB-1:0]    dig_m1;

    // (r+q) and (r-1+q) are just the low LB bits of q and q-1 modulo r.
    always_comb begin
        dig_neg = dig_i[D-1];
        dig_pos = !dig_neg && (dig_i != '0);
        q_src   = dig_neg ? qm_i : q_i;
        qm_src  = dig_pos ? q_i : qm_i;
        dig_m1  = dig_i[LB-1:0] - LB'(1);
        q_o     = (q_src << LB)  | {{(OUT_W-LB){1'b0}}, dig_i[LB-1:0]};
        qm_o    = (qm_src << LB) | {{(OUT_W-LB){1'b0}}, dig_m1};
        bad_o   = (dig_i == {1'b1, {(D-1){1'b0}}});
    end

endmodule

// File: rtl/rrp_otf_conv.sv
// Serial MSD-first converter from a signed-digit product word to a
// two's-complement result, one digit per cycle.
module rrp_otf_conv
    import rrp_otf_conv_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    rrp_otf_conv_if.slave      bus
);
    localparam int D     = digit_bits(RADIX);
    localparam int NDIG  = num_digits(WIDTH);
    localparam int OUT_W = out_bits(RADIX, WIDTH);
    localparam int CNT_W = $clog2(NDIG);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [D*NDIG-1:0]   data_q;
    logic [OUT_W-1:0]    q_q, qm_q;
    logic                err_q;

    logic [D-1:0]        cur_dig;
    logic [OUT_W-1:0]    step_q, step_qm;
    logic                step_bad;

    assign cur_dig = data_q[int'(cnt_q)*D +: D];

    rrp_otf_conv_step #(.RADIX(RADIX), .WIDTH(WIDTH)) u_step (
        .q_i   (q_q),
        .qm_i  (qm_q),
        .dig_i (cur_dig),
        .q_o   (step_q),
        .qm_o  (step_qm),
        .bad_o (step_bad)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid)       state_d = ST_CONV;
            ST_CONV: if (cnt_q == '0)        state_d = ST_DONE;
            ST_DONE: if (bus.out_ready)      state_d = ST_IDLE;
            default:                         state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state_q == ST_IDLE);
        bus.out_valid = (state_q == ST_DONE);
        bus.out_data  = q_q;
        bus.out_err   = err_q;
    end

    // The latched copy decouples the conversion from later in_data changes.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            data_q <= '0;
            q_q    <= '0;
            qm_q   <= '1;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.in_valid) begin
                    data_q <= bus.in_data;
                    q_q    <= '0;
                    qm_q   <= '1;
                    err_q  <= 1'b0;
                    cnt_q  <= CNT_W'(NDIG - 1);
                end
                ST_CONV: begin
                    q_q   <= step_q;
                    qm_q  <= step_qm;
                    err_q <= err_q | step_bad;
                    if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
